hall_conditioner: RTL and testbench
===================================

Name: hall_conditioner

Overview:
- Upstream front end for the hall sensor path.
- Synchronises and glitch-filters the three raw hall inputs, then decodes them into a 0..5 commutation sector and a rotation direction.
- Tracks electrical steps and emits exactly one clean single-cycle pulse per mechanical revolution (rev_pulse). rev_pulse drives the hall_sensor input of speed_calculation.
- Also flags invalid hall codes, skipped sectors and rotor stall for the motor controller.

Parameters:
- FILTER_CYCLES, 50: consecutive identical synchronised samples needed to accept a new hall code (1 us at 50 MHz); legal range 1..255.
- POLE_PAIRS, 4: motor pole pairs; steps per mechanical revolution = 6*POLE_PAIRS.
- STALL_CYCLES, 25_000_000: cycles with no valid step before stalled asserts; legal range 1..2^26-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- hall_a, hall_b, hall_c  input  1 each  raw asynchronous hall sensor lines.
- hall_state  output  3  filtered hall code {A,B,C}.
- state_valid  output  1  high once a valid filtered code has been decoded since reset.
- sector  output  3  commutation sector 0..5.
- dir  output  1  1 = forward, 0 = reverse.
- rev_pulse  output  1  one-cycle pulse per mechanical revolution.
- hall_fault  output  1  sticky fault flag.
- fault_code  output  2  01 = invalid code, 10 = skipped sector; holds the first fault seen.
- stalled  output  1  no valid step for STALL_CYCLES cycles.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. rst dominates every other event.
- Reset values:
  - hall_state = 000, sector = 0, dir = 1, state_valid = 0.
  - rev_pulse = 0, hall_fault = 0, fault_code = 00, stalled = 0.
  - step counter = 0, stall timer = 0, FSM = WAIT.
- Synchroniser: two flops per input, reset to 0.
- Filter:
  - Keep a candidate code and a counter.
  - If the synchronised code differs from the candidate: load candidate, set counter = 1.
  - Else: increment the counter, saturating.
  - When counter == FILTER_CYCLES and candidate != hall_state: hall_state <= candidate.
  - Latency: a clean input change appears on hall_state FILTER_CYCLES+2 cycles after the clock edge that samples it.
  - Any pulse shorter than FILTER_CYCLES cycles is ignored.
- Decode, forward order by sector: 101=0, 100=1, 110=2, 010=3, 011=4, 001=5. Codes 000 and 111 are invalid.
- Timing: all decode outputs (sector, dir, rev_pulse, fault) update one cycle after hall_state changes.
- FSM states WAIT, TRACK, FAULT:
  - WAIT: on the first valid code, load sector, state_valid = 1, go to TRACK. No step is counted and dir is unchanged. An invalid code in WAIT sets the fault (01) and goes to FAULT.
  - TRACK, new sector == (old+1) mod 6: dir = 1; step = (step == 6*POLE_PAIRS-1) ? 0 : step+1; rev_pulse = 1 on the wrap to 0.
  - TRACK, new sector == (old+5) mod 6: dir = 0; step = (step == 0) ? 6*POLE_PAIRS-1 : step-1; rev_pulse = 1 on the wrap from 0.
  - TRACK, any other valid sector: fault_code 10, hall_fault = 1, load the new sector, no step counted, dir unchanged. Remain in TRACK.
  - TRACK, invalid code: fault 01, sector holds, go to FAULT.
  - FAULT: on the next valid code, load sector with no step, go to TRACK; the step counter keeps its value.
- Fault flags: hall_fault and fault_code are sticky until rst. Only the first fault is recorded.
- Stall timer:
  - Cleared on every counted forward or reverse step.
  - Otherwise increments, saturating at STALL_CYCLES, only while state_valid = 1.
  - stalled = (timer == STALL_CYCLES). It clears in the same cycle the step is registered.
- Widths:
  - Step counter is wide enough for 6*POLE_PAIRS-1.
  - Stall timer is 26 bits; the filter counter is 8 bits.
- rev_pulse is registered and never asserts on two consecutive cycles. This is guaranteed because FILTER_CYCLES >= 1 plus the decode stage.

Optional Feature:
- Macro: HALL_INVERT_EN.
- Defined: each synchronised hall bit is inverted before the filter, for open-collector active-low sensors. hall_state and decode operate on the inverted values.
- Undefined: no inversion; behaviour exactly as above.

Test Plan:
- Forward rotation (FILTER_CYCLES=4, POLE_PAIRS=2): 25 clean forward codes each held 20 cycles, starting at 101 -> dir=1, exactly 2 rev_pulse, each one cycle wide, after steps 12 and 24; no fault.
- Glitch rejection: from 101, pulse hall_a low for 3 cycles -> hall_state stays 101, sector stays 0. A 4-cycle pulse is accepted as 001: sector=5, dir=0. The return to 101 gives a forward step with dir=1.
- Reverse rotation: 12 reverse steps from sector 0 -> dir=0 after the first step; rev_pulse on the first step (wrap 0->11) and none on the following 11.
- Faults: apply 111 in TRACK -> hall_fault=1, fault_code=01, sector held. Then 110 -> TRACK, sector=2. A later skip 2->4 leaves fault_code at 01.
- Stall (STALL_CYCLES=100): hold a valid code -> stalled=1 exactly 100 cycles after the last step; the next valid step clears stalled.
- Reset mid-operation: assert rst for 1 cycle during forward rotation with step=7 -> all outputs at reset values on the next cycle; step counter 0, state_valid=0 until a valid code is re-decoded.

Source files
------------

// File: rtl/hall_conditioner.sv
// Hall sensor front end: sync + glitch filter, sector/direction decode, revolution pulse, fault and stall flags.
// Optional build macro HALL_INVERT_EN inverts the synchronised hall bits for active-low sensors.
module hall_conditioner #(
    parameter int FILTER_CYCLES = 50,
    parameter int POLE_PAIRS    = 4,
    parameter int STALL_CYCLES  = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hall_a,
    input  logic       hall_b,
    input  logic       hall_c,
    output logic [2:0] hall_state,
    output logic       state_valid,
    output logic [2:0] sector,
    output logic       dir,
    output logic       rev_pulse,
    output logic       hall_fault,
    output logic [1:0] fault_code,
    output logic       stalled
);

    localparam int STEPS  = 6 * POLE_PAIRS;
    localparam int STEP_W = $clog2(STEPS);
    localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_ZERO = '0;
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [7:0]  FILT_N  = 8'(FILTER_CYCLES);
    localparam logic [25:0] STALL_N = 26'(STALL_CYCLES);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    localparam logic [1:0] FC_INVALID = 2'b01;
    localparam logic [1:0] FC_SKIP    = 2'b10;

    // {valid, sector} for a hall code in forward rotation order
    function automatic logic [3:0] decode(input logic [2:0] code);
        case (code)
            3'b101:  decode = 4'b1_000;
            3'b100:  decode = 4'b1_001;
            3'b110:  decode = 4'b1_010;
            3'b010:  decode = 4'b1_011;
            3'b011:  decode = 4'b1_100;
            3'b001:  decode = 4'b1_101;
            default: decode = 4'b0_000;
        endcase
    endfunction

    logic [2:0] sync1_q, sync2_q, code_s;
    logic [2:0] cand_q, hs_q;
    logic [7:0] cnt_q;
    logic       chg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= {hall_a, hall_b, hall_c};
            sync2_q <= sync1_q;
        end
    end

`ifdef HALL_INVERT_EN
    assign code_s = ~sync2_q;
`else
    assign code_s = sync2_q;
`endif

    // chg_q marks the cycle after hall_state took a new code, so decode runs exactly once per change
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q <= 3'b000;
            cnt_q  <= 8'd0;
            hs_q   <= 3'b000;
            chg_q  <= 1'b0;
        end else begin
            chg_q <= 1'b0;
            if (code_s != cand_q) begin
                cand_q <= code_s;
                cnt_q  <= 8'd1;
            end else if (cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (cnt_q == FILT_N && cand_q != hs_q) begin
                hs_q  <= cand_q;
                chg_q <= 1'b1;
            end
        end
    end

    logic [1:0]        fsm_q, fsm_d;
    logic [2:0]        sector_q, sector_d;
    logic              dir_q, dir_d;
    logic              valid_q, valid_d;
    logic              rev_q, rev_d;
    logic              fault_q, fault_d;
    logic [1:0]        fcode_q, fcode_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [25:0]       timer_q, timer_d;

    logic       dec_ok, stepped, flt_req;
    logic [2:0] dec_sec, sec_fwd, sec_rev;
    logic [1:0] flt_code;

    assign sec_fwd = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
    assign sec_rev = (sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1;

    always_comb begin
        fsm_d    = fsm_q;
        sector_d = sector_q;
        dir_d    = dir_q;
        valid_d  = valid_q;
        rev_d    = 1'b0;
        fault_d  = fault_q;
        fcode_d  = fcode_q;
        step_d   = step_q;
        timer_d  = timer_q;
        stepped  = 1'b0;
        flt_req  = 1'b0;
        flt_code = FC_INVALID;
        {dec_ok, dec_sec} = decode(hs_q);

        if (chg_q) begin
            case (fsm_q)
                S_TRACK: begin
                    if (!dec_ok) begin
                        flt_req = 1'b1;
                        fsm_d   = S_FAULT;
                    end else if (dec_sec == sec_fwd) begin
                        sector_d = dec_sec;
                        dir_d    = 1'b1;
                        stepped  = 1'b1;
                        rev_d    = (step_q == STEP_MAX);
                        step_d   = (step_q == STEP_MAX) ? STEP_ZERO : step_q + STEP_ONE;
                    end else if (dec_sec == sec_rev) begin
                        sector_d = dec_sec;
                        dir_d    = 1'b0;
                        stepped  = 1'b1;
                        rev_d    = (step_q == STEP_ZERO);
                        step_d   = (step_q == STEP_ZERO) ? STEP_MAX : step_q - STEP_ONE;
                    end else begin
                        sector_d = dec_sec;
                        flt_req  = 1'b1;
                        flt_code = FC_SKIP;
                    end
                end
                S_WAIT, S_FAULT: begin
                    if (dec_ok) begin
                        sector_d = dec_sec;
                        valid_d  = 1'b1;
                        fsm_d    = S_TRACK;
                    end else begin
                        flt_req = 1'b1;
                        fsm_d   = S_FAULT;
                    end
                end
                default: fsm_d = S_WAIT;
            endcase
        end

        // only the first fault is kept until reset
        if (flt_req && !fault_q) begin
            fault_d = 1'b1;
            fcode_d = flt_code;
        end

        if (stepped) begin
            timer_d = 26'd0;
        end else if (valid_q && timer_q != STALL_N) begin
            timer_d = timer_q + 26'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= S_WAIT;
            sector_q <= 3'd0;
            dir_q    <= 1'b1;
            valid_q  <= 1'b0;
            rev_q    <= 1'b0;
            fault_q  <= 1'b0;
            fcode_q  <= 2'b00;
            step_q   <= STEP_ZERO;
            timer_q  <= 26'd0;
        end else begin
            fsm_q    <= fsm_d;
            sector_q <= sector_d;
            dir_q    <= dir_d;
            valid_q  <= valid_d;
            rev_q    <= rev_d;
            fault_q  <= fault_d;
            fcode_q  <= fcode_d;
            step_q   <= step_d;
            timer_q  <= timer_d;
        end
    end

    assign hall_state  = hs_q;
    assign state_valid = valid_q;
    assign sector      = sector_q;
    assign dir         = dir_q;
    assign rev_pulse   = rev_q;
    assign hall_fault  = fault_q;
    assign fault_code  = fcode_q;
    assign stalled     = (timer_q == STALL_N);

endmodule

// File: tb/tb_hall_conditioner.sv
// Bench for hall_conditioner: per-cycle comparison against a behavioural model plus directed literal checks.
module tb_hall_conditioner;

    localparam int F     = 4;
    localparam int PP    = 2;
    localparam int SC    = 100;
    localparam int STEPS = 6 * PP;
    localparam int HL    = F + 4;
    localparam int M_WAIT = 0, M_TRACK = 1, M_FLT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       hall_a, hall_b, hall_c;
    logic [2:0] hall_state, sector;
    logic       state_valid, dir, rev_pulse, hall_fault, stalled;
    logic [1:0] fault_code;

    hall_conditioner #(.FILTER_CYCLES(F), .POLE_PAIRS(PP), .STALL_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .hall_a(hall_a), .hall_b(hall_b), .hall_c(hall_c),
        .hall_state(hall_state), .state_valid(state_valid), .sector(sector), .dir(dir),
        .rev_pulse(rev_pulse), .hall_fault(hall_fault), .fault_code(fault_code), .stalled(stalled)
    );

    always #5 clk = ~clk;

    logic [2:0] seq [0:5] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    int checks = 0, errors = 0;
    bit chk_en = 0;
    int rev_cnt = 0;

    // model state
    logic [2:0] hist [0:HL-1];
    logic [2:0] m_hs;
    bit         m_valid, m_dir, m_rev, m_fault, m_pend;
    logic [1:0] m_code;
    int         m_sector, m_step, m_timer, m_mode;

    function automatic int sec_of(input logic [2:0] c);
        for (int i = 0; i < 6; i++) if (seq[i] == c) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input logic [1:0] c);
        if (!m_fault) begin
            m_fault = 1;
            m_code  = c;
        end
    endtask

    // Model: hall_state takes code X once X has been seen for exactly F consecutive
    // synchronised samples (two-cycle synchroniser delay); decode reacts one cycle later.
    initial begin : model_p
        logic [2:0] x;
        bit run, stepped, old_valid;
        int s;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int k = 0; k < HL; k++) hist[k] = 3'b000;
                m_hs = 3'b000; m_valid = 0; m_sector = 0; m_dir = 1; m_rev = 0;
                m_fault = 0; m_code = 2'b00; m_step = 0; m_timer = 0; m_mode = M_WAIT; m_pend = 0;
            end else begin
                stepped = 0;
                old_valid = m_valid;
                m_rev = 0;
                if (m_pend) begin
                    s = sec_of(m_hs);
                    if (m_mode == M_TRACK) begin
                        if (s < 0) begin
                            flag(2'b01); m_mode = M_FLT;
                        end else if (s == (m_sector + 1) % 6) begin
                            m_dir = 1; m_step = (m_step + 1) % STEPS; m_rev = (m_step == 0);
                            stepped = 1; m_sector = s;
                        end else if (s == (m_sector + 5) % 6) begin
                            m_dir = 0; m_rev = (m_step == 0); m_step = (m_step + STEPS - 1) % STEPS;
                            stepped = 1; m_sector = s;
                        end else begin
                            flag(2'b10); m_sector = s;
                        end
                    end else begin
                        if (s >= 0) begin
                            m_sector = s; m_valid = 1; m_mode = M_TRACK;
                        end else begin
                            flag(2'b01); m_mode = M_FLT;
                        end
                    end
                end
                if (stepped) m_timer = 0;
                else if (old_valid && m_timer < SC) m_timer++;
                for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = {hall_a, hall_b, hall_c};
                x = hist[3];
                run = 1;
                for (int k = 3; k <= F + 2; k++) if (hist[k] != x) run = 0;
                if (hist[F+3] == x) run = 0;
                m_pend = 0;
                if (run && x != m_hs) begin
                    m_hs = x; m_pend = 1;
                end
            end
        end
    end

    initial begin : compare_p
        bit prev_rev;
        prev_rev = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("hall_state", hall_state, m_hs);
                chk("state_valid", state_valid, m_valid);
                chk("sector", sector, m_sector);
                chk("dir", dir, m_dir);
                chk("rev_pulse", rev_pulse, m_rev);
                chk("hall_fault", hall_fault, m_fault);
                chk("fault_code", fault_code, m_code);
                chk("stalled", stalled, int'(m_timer == SC));
                chk("rev_width", int'(prev_rev && rev_pulse), 0);
                if (rev_pulse) rev_cnt++;
                prev_rev = rev_pulse;
            end
        end
    end

    task automatic hold(input logic [2:0] code, input int n);
        repeat (n) begin
            {hall_a, hall_b, hall_c} = code;
            @(negedge clk);
        end
    endtask

    initial begin : stim_p
        int base, n, r;
        bit seen;
        logic [2:0] c;
        rst = 1'b1;
        {hall_a, hall_b, hall_c} = 3'b101;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_hall_state", hall_state, 0);
        chk("rst_dir", dir, 1);
        chk("rst_valid", state_valid, 0);
        chk("rst_stalled", stalled, 0);
        chk("rst_fault_code", fault_code, 0);
        rst = 1'b0;

        // forward: 25 codes starting at 101 -> 24 steps, two revolutions
        base = rev_cnt;
        for (int i = 0; i < 25; i++) hold(seq[i % 6], 20);
        chk("fwd_revs", rev_cnt - base, 2);
        chk("fwd_dir", dir, 1);
        chk("fwd_fault", hall_fault, 0);
        chk("fwd_sector", sector, 0);

        // glitch rejection then a just-long-enough pulse
        hold(3'b001, 3);
        hold(3'b101, 20);
        chk("glitch_hs", hall_state, 3'b101);
        chk("glitch_sector", sector, 0);
        hold(3'b001, 4);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            hold(3'b101, 1);
            if (!seen && sector == 3'd5) begin
                seen = 1;
                chk("pulse_dir", dir, 0);
            end
        end
        chk("pulse_seen", seen, 1);
        chk("pulse_back_dir", dir, 1);
        chk("pulse_back_sector", sector, 0);

        // reverse: 12 steps from sector 0, one wrap on the first step
        base = rev_cnt;
        for (int k = 1; k <= 12; k++) hold(seq[(6 - (k % 6)) % 6], 20);
        chk("rev_revs", rev_cnt - base, 1);
        chk("rev_dir", dir, 0);

        // faults
        hold(3'b111, 20);
        chk("inv_fault", hall_fault, 1);
        chk("inv_code", fault_code, 1);
        chk("inv_sector", sector, 0);
        hold(3'b110, 20);
        chk("recover_sector", sector, 2);
        hold(3'b011, 20);
        chk("skip_code", fault_code, 1);
        chk("skip_sector", sector, 4);

        // stall
        n = 0;
        do begin hold(3'b001, 1); n++; end while (sector != 3'd5 && n < 30);
        chk("stall_step_seen", sector, 5);
        chk("stall_clear_step", stalled, 0);
        n = 0;
        while (!stalled && n < 200) begin hold(3'b001, 1); n++; end
        chk("stall_cycles", n, 100);
        n = 0;
        do begin hold(3'b101, 1); n++; end while (sector != 3'd0 && n < 30);
        chk("unstall_sector", sector, 0);
        chk("unstall", stalled, 0);

        // reset mid-rotation at step 7
        n = 0;
        while (m_step != 7 && n < 40) begin hold(seq[(m_sector + 1) % 6], 20); n++; end
        chk("steer_step", m_step, 7);
        c = seq[(m_sector + 1) % 6];
        rst = 1'b1;
        hold(c, 1);
        chk("mrst_hall_state", hall_state, 0);
        chk("mrst_valid", state_valid, 0);
        chk("mrst_sector", sector, 0);
        chk("mrst_dir", dir, 1);
        chk("mrst_fault", hall_fault, 0);
        chk("mrst_code", fault_code, 0);
        chk("mrst_rev", rev_pulse, 0);
        chk("mrst_stalled", stalled, 0);
        rst = 1'b0;
        hold(c, 5);
        chk("mrst_valid_wait", state_valid, 0);
        hold(c, 20);
        chk("mrst_valid_back", state_valid, 1);

        // randomized rotation with glitches, invalid codes and resets
        repeat (400) begin
            r = $urandom_range(0, 19);
            if (r < 9) c = seq[(m_sector + 1) % 6];
            else if (r < 15) c = seq[(m_sector + 5) % 6];
            else c = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                hold(c, 1);
                rst = 1'b0;
            end
            hold(c, $urandom_range(1, 14));
        end

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
